// File: rtl/mul_seq_ctrl_if.sv
// Requester/datapath <-> sequencer bundle: start/abort/stall inputs, condition bit, one-hot strobes.
// master = requester + datapath side, slave = controller side.
interface mul_seq_ctrl_if;
  logic       start;
  logic       abort;
  logic       en;
  logic       b0;
  logic       busy;
  logic       t_ld;
  logic       t_add;
  logic       t_shr;
  logic       t_wr;
  logic       done;
  logic       aborted;
  logic [2:0] state;

  modport master (
    output start, abort, en, b0,
    input  busy, t_ld, t_add, t_shr, t_wr, done, aborted, state
  );

  modport slave (
    input  start, abort, en, b0,
    output busy, t_ld, t_add, t_shr, t_wr, done, aborted, state
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Shift-and-add multiplier sequencer: done arrives 2N+k+3 cycles after start (k = ones seen on b0).
// en=0 freezes state/count and gates every strobe; abort returns to IDLE with a one-cycle aborted pulse.
module mul_seq_ctrl #(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          res,
  mul_seq_ctrl_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_TEST  = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic          aborted_q;

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= 1'b0;
      if (bus.abort && (state_q != S_IDLE)) begin
        // abort wins over stall: a frozen operation can still be cancelled
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        aborted_q <= 1'b1;
      end else begin
        case (state_q)
          // IDLE ignores en; an abort in IDLE only blocks start
          S_IDLE: if (bus.start && !bus.abort) state_q <= S_LOAD;
          S_LOAD: if (bus.en) begin
            cnt_q   <= CW'(N);
            state_q <= S_TEST;
          end
          S_TEST: if (bus.en) state_q <= bus.b0 ? S_ADD : S_SHIFT;
          S_ADD:  if (bus.en) state_q <= S_SHIFT;
          S_SHIFT: if (bus.en) begin
            cnt_q   <= cnt_q - CW'(1);
            state_q <= (cnt_q == CW'(1)) ? S_WRITE : S_TEST;
          end
          S_WRITE: if (bus.en) state_q <= S_DONE;
          S_DONE:  if (bus.en) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.t_ld    = bus.en && (state_q == S_LOAD);
  assign bus.t_add   = bus.en && (state_q == S_ADD);
  assign bus.t_shr   = bus.en && (state_q == S_SHIFT);
  assign bus.t_wr    = bus.en && (state_q == S_WRITE);
  assign bus.done    = bus.en && (state_q == S_DONE);
  assign bus.aborted = aborted_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: N=8 instance checked by a strobe scoreboard, N=1 instance by a per-cycle table.
module tb_mul_seq_ctrl;

  typedef struct {
    int         cyc;
    logic [5:0] code;
  } ev_t;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  ev_t  exp_q[$];
  int   op_lo = 1;
  int   op_hi = 0;
  logic [7:0] pat8 = 8'h00;
  logic [7:0] m8 = 8'h00;

  mul_seq_ctrl_if if8 ();
  mul_seq_ctrl_if if1 ();

  mul_seq_ctrl #(.N(8)) dut8 (.clk(clk), .res(res), .bus(if8.slave));
  mul_seq_ctrl #(.N(1)) dut1 (.clk(clk), .res(res), .bus(if1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // datapath stand-in: multiplier register loaded on t_ld, shifted on t_shr
  always @(posedge clk) begin
    if (if8.t_ld) m8 <= pat8;
    else if (if8.t_shr) m8 <= m8 >> 1;
  end
  assign if8.b0 = m8[0];
  assign if1.b0 = 1'b1;

  function automatic logic [5:0] code_of(input logic ab, dn, wr, sh, ad, ld);
    return {ab, dn, wr, sh, ad, ld};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // expected strobe stream of one N=8 operation starting (LOAD) at cycle base
  task automatic push_op(input int base, input logic [7:0] p, input int stall_len,
                         input int cut, input int abort_at, input int busy_last);
    logic [5:0] seq[$];
    int shifts = 0;
    seq.push_back(6'h01);
    for (int i = 0; i < 8; i++) begin
      seq.push_back(6'h00);
      if (p[i]) seq.push_back(6'h02);
      shifts++;
      if (shifts == 2) for (int s = 0; s < stall_len; s++) seq.push_back(6'h00);
      seq.push_back(6'h04);
    end
    seq.push_back(6'h08);
    seq.push_back(6'h10);
    for (int r = 0; r < seq.size(); r++)
      if ((r + 1) <= cut && seq[r] != 6'h00) exp_q.push_back('{base + r, seq[r]});
    if (abort_at > 0) exp_q.push_back('{base + abort_at - 1, 6'h20});
    op_lo = base;
    op_hi = base + ((busy_last > 0) ? busy_last : seq.size()) - 1;
  endtask

  task automatic start8(input logic [7:0] p, input int stall_len, input int cut,
                        input int abort_at, input int busy_last);
    pat8 = p;
    if8.start = 1'b1;
    push_op(cyc + 1, p, stall_len, cut, abort_at, busy_last);
    tick();
    if8.start = 1'b0;
  endtask

  // scoreboard / protocol monitor for the N=8 instance, sampled mid-cycle
  always @(negedge clk) begin
    logic [5:0] code;
    ev_t e;
    code = code_of(if8.aborted, if8.done, if8.t_wr, if8.t_shr, if8.t_add, if8.t_ld);
    n_tests++;
    assert (($countones(code[4:0]) <= 1) === 1'b1) else begin
      n_fail++;
      $error("FAIL onehot cyc %0d: observed %0h expected at most one strobe", cyc, code);
    end
    n_tests++;
    assert (if8.busy === (cyc >= op_lo && cyc <= op_hi)) else begin
      n_fail++;
      $error("FAIL busy cyc %0d: observed %0b expected %0b", cyc, if8.busy, (cyc >= op_lo && cyc <= op_hi));
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      assert (exp_q[0].cyc >= cyc) else begin
        n_fail++;
        $error("FAIL missed cyc %0d: observed none expected %0h", exp_q[0].cyc, exp_q[0].code);
        void'(exp_q.pop_front());
      end
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      n_tests++;
      assert (code === e.code) else begin
        n_fail++;
        $error("FAIL strobe cyc %0d: observed %0h expected %0h", cyc, code, e.code);
      end
    end else if (code != 6'h00) begin
      n_tests++;
      assert (code === 6'h00) else begin
        n_fail++;
        $error("FAIL unexpected cyc %0d: observed %0h expected 0", cyc, code);
      end
    end
  end

  int st1[14] = '{1, 2, 3, 4, 5, 6, 0, 1, 2, 3, 4, 5, 6, 0};

  initial begin
    logic [5:0] want;
    if8.start = 1'b0; if8.abort = 1'b0; if8.en = 1'b1;
    if1.start = 1'b0; if1.abort = 1'b0; if1.en = 1'b1;
    tick();
    tick();
    res = 1'b0;
    chk("rst_state", {5'd0, if8.state}, 8'd0);
    chk("rst_busy", {7'd0, if8.busy}, 8'd0);
    chk("rst_aborted", {7'd0, if8.aborted}, 8'd0);
    tick();

    // zero multiplier: t_wr at 18, done at 19
    start8(8'h00, 0, 99, 0, 0);
    repeat (22) tick();

    // 0xA5: four adds, done at 23
    start8(8'hA5, 0, 99, 0, 0);
    repeat (26) tick();

    // stall 5 cycles entering the 2nd SHIFT: done moves to 24
    start8(8'h00, 5, 99, 0, 0);
    repeat (4) tick();
    if8.en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_state", {5'd0, if8.state}, 8'd4);
      tick();
    end
    if8.en = 1'b1;
    repeat (18) tick();

    // abort while WRITE is held by a stall: no t_wr, no done
    start8(8'h00, 0, 17, 19, 18);
    repeat (17) tick();
    chk("abort_in_write", {5'd0, if8.state}, 8'd5);
    if8.en = 1'b0;
    if8.abort = 1'b1;
    tick();
    if8.abort = 1'b0;
    if8.en = 1'b1;
    chk("abort_state", {5'd0, if8.state}, 8'd0);
    chk("abort_pulse", {7'd0, if8.aborted}, 8'd1);
    tick();
    chk("abort_pulse_end", {7'd0, if8.aborted}, 8'd0);
    tick();

    // abort together with start in IDLE: nothing happens
    if8.start = 1'b1;
    if8.abort = 1'b1;
    tick();
    if8.start = 1'b0;
    if8.abort = 1'b0;
    chk("idle_abort_state", {5'd0, if8.state}, 8'd0);
    chk("idle_abort_pulse", {7'd0, if8.aborted}, 8'd0);
    tick();

    // reset in the 3rd ADD cycle (cycle 9) with b0 stuck at 1
    start8(8'hFF, 0, 9, 0, 9);
    repeat (8) tick();
    chk("rst_mid_pre", {5'd0, if8.state}, 8'd3);
    res = 1'b1;
    tick();
    res = 1'b0;
    chk("rst_mid_state", {5'd0, if8.state}, 8'd0);
    chk("rst_mid_busy", {7'd0, if8.busy}, 8'd0);
    chk("rst_mid_done", {7'd0, if8.done}, 8'd0);
    tick();

    // full operation after the reset
    start8(8'hA5, 0, 99, 0, 0);
    repeat (26) tick();

    // N=1, b0=1, start held: LOAD TEST ADD SHIFT WRITE DONE, IDLE, LOAD again
    if1.start = 1'b1;
    tick();
    for (int r = 0; r < 14; r++) begin
      case (st1[r])
        1: want = 6'h01;
        3: want = 6'h02;
        4: want = 6'h04;
        5: want = 6'h08;
        6: want = 6'h10;
        default: want = 6'h00;
      endcase
      chk("n1_state", {5'd0, if1.state}, 8'(st1[r]));
      chk("n1_strobes", {2'd0, code_of(if1.aborted, if1.done, if1.t_wr, if1.t_shr, if1.t_add, if1.t_ld)}, {2'd0, want});
      tick();
    end
    if1.start = 1'b0;
    repeat (8) tick();

    n_tests++;
    assert (exp_q.size() === 0) else begin
      n_fail++;
      $error("FAIL leftover: observed %0d pending events expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Control automaton that sequences a shift-and-add multiplier datapath: register load, conditional add, right shift, result write.
- Sits between a requester (start/done handshake) and the datapath, which owns the operand/accumulator registers.
- Emits one-hot microoperation strobes and consumes one datapath condition bit (multiplier LSB).
- Provides stall (en) and abort control, plus a debug state output.

Parameters:
- N, 8, multiplier width = number of add/shift iterations; legal range 1..64.
- CW, $clog2(N+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- res  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  synchronous cancel of a running operation.
- en  in  1  datapath ready; 0 = stall.
- b0  in  1  current multiplier LSB from datapath.
- busy  out  1  operation in progress (state != IDLE).
- t_ld  out  1  load operands, clear accumulator.
- t_add  out  1  accumulator += multiplicand.
- t_shr  out  1  shift {acc, multiplier} right by 1.
- t_wr  out  1  write product to result register.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  one-cycle pulse after an accepted abort.
- state  out  3  current state encoding (debug).

Behaviour:
- Reset (res=1 at a clk edge): state=IDLE, cnt=0, aborted=0. All strobes, busy and done are 0 in the following cycle. res has priority over all inputs.
- State encoding: IDLE=0, LOAD=1, TEST=2, ADD=3, SHIFT=4, WRITE=5, DONE=6. Code 7 is illegal and goes to IDLE on the next edge with no strobes.
- Transitions, applied when en=1 and abort=0:
  - IDLE: start=1 -> LOAD; otherwise stay.
  - LOAD: cnt<=N -> TEST.
  - TEST: b0=1 -> ADD; b0=0 -> SHIFT.
  - ADD -> SHIFT.
  - SHIFT: cnt<=cnt-1. If cnt==1 -> WRITE, else -> TEST.
  - WRITE -> DONE.
  - DONE -> IDLE.
- Outputs:
  - Moore decode of the state register: t_ld=LOAD, t_add=ADD, t_shr=SHIFT, t_wr=WRITE, done=DONE.
  - Every decoded strobe is ANDed with en.
  - At most one strobe is high in any cycle.
  - busy is not gated by en.
- Stall: with en=0 in any non-IDLE state, state and cnt hold and all strobes are 0. The stalled operation resumes unchanged when en returns to 1. In IDLE, en is ignored; start is accepted regardless of en.
- Abort:
  - abort=1 at an edge in any non-IDLE state -> IDLE and cnt<=0.
  - aborted=1 for exactly the next cycle.
  - No t_wr and no done are issued for that operation.
  - Abort overrides stall and start.
  - abort in IDLE has no effect: no pulse, start is blocked that edge.
- start while busy is ignored; there is no queuing.
- Back-to-back: start=1 sampled in the IDLE cycle right after DONE begins a new operation. Minimum gap is one IDLE cycle.
- Latency, no stalls, k = number of ones consumed on b0:
  - start sampled at edge E0; LOAD is cycle 1.
  - done is high in cycle 2N+k+3.
  - busy is high for cycles 1 through 2N+k+3.
- b0 is sampled only in TEST; the datapath must present the shifted LSB by then.

Test Plan:
- Reset mid-operation: N=8, b0=1 always, assert res in the 3rd ADD cycle -> next cycle state=0, busy=0, no strobes, no done; a later start runs a full operation.
- Zero multiplier: N=8, b0=0 every TEST, en=1 -> t_ld in cycle 1, 8 t_shr pulses, 0 t_add, t_wr in cycle 18, done in cycle 19, busy high cycles 1–19.
- Pattern 0xA5, LSB first (b0 sequence 1,0,1,0,0,1,0,1) -> t_add exactly at the 4 TESTs with b0=1, done in cycle 23. Check one-hot strobes every cycle.
- Stall: same as the zero-multiplier case, but en=0 for 5 cycles entering the 2nd SHIFT -> no strobes during the stall, state=4 held, done shifts to cycle 24, total t_shr count still 8.
- Abort during WRITE: abort=1 with state=5 -> next cycle state=0 and aborted=1 for one cycle; t_wr and done never asserted. abort+start together in IDLE -> stays IDLE, aborted=0.
- Edge widths: N=1 with b0=1 -> LOAD, TEST, ADD, SHIFT, WRITE, done in cycle 6. start held high continuously -> a new LOAD exactly 2 cycles after each done, and start is ignored while busy.
